// File: rtl/bitwise_pkg.sv
// Shared types and defaults for the bitwise result stage.
package bitwise_pkg;

  typedef enum logic [1:0] {
    BW_AND  = 2'd0,
    BW_OR   = 2'd1,
    BW_XOR  = 2'd2,
    BW_XNOR = 2'd3
  } bw_op_e;

  localparam int unsigned BW_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/bitwise_fifo2.sv
// Generic 2-entry valid/ready FIFO; output holds the last popped word while empty.
module bitwise_fifo2 #(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] last_q;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              push, pop;

  // Ready depends only on registered occupancy, never on out_ready_i.
  assign in_ready_o  = ~rst && (occ_q != 2'd2);
  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = out_valid_o ? mem_q[head_q] : last_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    head_d = pop ? ~head_q : head_q;
    tail_d = push ? ~tail_q : tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= RESET_VAL;
      mem_q[1] <= RESET_VAL;
      last_q   <= RESET_VAL;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) mem_q[tail_q] <= in_data_i;
      if (pop) last_q <= mem_q[head_q];
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/bitwise_result_stage.sv
// Selects AND/OR/XOR/XNOR per transaction, attaches zero/parity flags, buffers
// results in a 2-entry queue and counts delivered results.
module bitwise_result_stage
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = BW_WIDTH_DEFAULT,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_and,
  input  logic [WIDTH-1:0] in_or,
  input  logic [WIDTH-1:0] in_xor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
  } bw_entry_t;

  localparam int unsigned EntryW   = $bits(bw_entry_t);
  localparam bw_entry_t   EntryRst = '{result: '0, zero: 1'b1, parity: 1'b0};

  bw_entry_t        push_entry;
  bw_entry_t        head_entry;
  logic [WIDTH-1:0] sel;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    sel = '0;
    case (bw_op_e'(in_op))
      BW_AND:  sel = in_and;
      BW_OR:   sel = in_or;
      BW_XOR:  sel = in_xor;
      BW_XNOR: sel = ~in_xor;
      default: sel = '0;
    endcase
    push_entry.result = sel;
    push_entry.zero   = (sel == '0);
    push_entry.parity = ^sel;
  end

  bitwise_fifo2 #(
    .DATA_W   (EntryW),
    .RESET_VAL(EntryRst)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (push_entry),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (head_entry)
  );

  assign out_result = head_entry.result;
  assign out_zero   = head_entry.zero;
  assign out_parity = head_entry.parity;

  assign count_d = (out_valid && out_ready) ? count_q + 1'b1 : count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign out_count = count_q;

endmodule

// File: tb/tb_bitwise_result_stage.sv
// Directed bench for bitwise_result_stage; inputs driven and outputs sampled on negedge.
module tb_bitwise_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_and, in_or, in_xor;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_zero;
  logic       out_parity;
  logic [3:0] out_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bitwise_result_stage #(
    .WIDTH(4),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_and    (in_and),
    .in_or     (in_or),
    .in_xor    (in_xor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_zero  (out_zero),
    .out_parity(out_parity),
    .out_count (out_count)
  );

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] a, input logic [3:0] o,
                       input logic [3:0] x);
    in_valid = v; in_op = op; in_and = a; in_or = o; in_xor = x;
  endtask

  task automatic do_reset();
    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL init_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL init_valid got=%b exp=0", out_valid); end
    checks++;
    if ({out_result, out_zero, out_parity} !== 6'b0000_1_0) begin
      failures++;
      $display("FAIL init_out got=%b %b %b exp=0000 1 0", out_result, out_zero, out_parity);
    end
    checks++; if (out_count !== 4'd0) begin failures++; $display("FAIL init_count got=%0d exp=0", out_count); end
    // e1 pushed, then e1 popped while e2 pushed, then e3 pushed: occ=2, count=1
    @(negedge clk); drive(1'b1, 2'd0, 4'b0001, 4'd0, 4'd0);
    @(negedge clk); drive(1'b1, 2'd0, 4'b0010, 4'd0, 4'd0); out_ready = 1'b1;
    @(negedge clk); drive(1'b1, 2'd0, 4'b0100, 4'd0, 4'd0); out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    checks++; if (out_count !== 4'd1) begin failures++; $display("FAIL pre_rst_count got=%0d exp=1", out_count); end
    checks++; if (out_result !== 4'b0010) begin failures++; $display("FAIL pre_rst_head got=%b exp=0010", out_result); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
    checks++; if (out_count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", out_count); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_hold_ready got=%b exp=0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", in_ready); end
    checks++;
    if ({out_valid, out_result, out_zero, out_parity} !== 7'b0_0000_1_0) begin
      failures++;
      $display("FAIL rel_out got=%b %b %b %b exp=0 0000 1 0", out_valid, out_result, out_zero, out_parity);
    end
  endtask

  task automatic test_op_select();
    logic [3:0] exp_res [4];
    logic       exp_par [4];
    exp_res[0] = 4'b1000; exp_res[1] = 4'b1110; exp_res[2] = 4'b0110; exp_res[3] = 4'b1001;
    exp_par[0] = 1'b1;    exp_par[1] = 1'b1;    exp_par[2] = 1'b0;    exp_par[3] = 1'b0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 4'b1000, 4'b1110, 4'b0110);
      @(negedge clk);
      checks++;
      if ({out_valid, out_result, out_zero, out_parity} !== {1'b1, exp_res[i], 1'b0, exp_par[i]}) begin
        failures++;
        $display("FAIL op%0d got=%b %b %b %b exp=1 %b 0 %b", i, out_valid, out_result, out_zero,
                 out_parity, exp_res[i], exp_par[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_count !== 4'd4) begin failures++; $display("FAIL op_count got=%0d exp=4", out_count); end
    checks++;
    if ({out_valid, out_result} !== 5'b0_1001) begin
      failures++;
      $display("FAIL empty_hold got=%b %b exp=0 1001", out_valid, out_result);
    end
  endtask

  task automatic test_zero();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 2'd1, 4'd0, 4'b0111, 4'd0);
    @(negedge clk);
    checks++;
    if ({out_result, out_zero, out_parity} !== 6'b0111_0_1) begin
      failures++;
      $display("FAIL nz_or got=%b %b %b exp=0111 0 1", out_result, out_zero, out_parity);
    end
    drive(1'b1, 2'd0, 4'b0000, 4'b1111, 4'b1111);
    @(negedge clk);
    checks++;
    if ({out_result, out_zero, out_parity} !== 6'b0000_1_0) begin
      failures++;
      $display("FAIL zero_and got=%b %b %b exp=0000 1 0", out_result, out_zero, out_parity);
    end
    drive(1'b1, 2'd1, 4'b0000, 4'b0011, 4'd0);
    @(negedge clk);
    drive(1'b1, 2'd3, 4'b1111, 4'b1111, 4'b1111);
    @(negedge clk);
    checks++;
    if ({out_result, out_zero, out_parity} !== 6'b0000_1_0) begin
      failures++;
      $display("FAIL zero_xnor got=%b %b %b exp=0000 1 0", out_result, out_zero, out_parity);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 2'd0, 4'b0001, 4'd0, 4'd0);
    @(negedge clk);
    drive(1'b1, 2'd0, 4'b0010, 4'd0, 4'd0);
    @(negedge clk);
    drive(1'b1, 2'd0, 4'b0100, 4'd0, 4'd0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    checks++; if (out_result !== 4'b0001) begin failures++; $display("FAIL bp_head got=%b exp=0001", out_result); end
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_result} !== 6'b0_1_0001) begin
      failures++;
      $display("FAIL bp_stable got=%b %b %b exp=0 1 0001", in_ready, out_valid, out_result);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_result} !== 5'b1_0010) begin
      failures++;
      $display("FAIL bp_drain1 got=%b %b exp=1 0010", in_ready, out_result);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_result} !== 5'b1_0100) begin
      failures++;
      $display("FAIL bp_drain2 got=%b %b exp=1 0100", out_valid, out_result);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_count} !== 5'b0_0011) begin
      failures++;
      $display("FAIL bp_end got=%b %0d exp=0 3", out_valid, out_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 2'd0, 4'(k), 4'd0, 4'd0);
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_result} !== {1'b1, 1'b1, 4'(k)}) begin
        failures++;
        $display("FAIL stream%0d got=%b %b %b exp=1 1 %b", k, in_ready, out_valid, out_result, 4'(k));
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_count} !== 5'b0_1010) begin
      failures++;
      $display("FAIL stream_end got=%b %0d exp=0 10", out_valid, out_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 2'd2, 4'd0, 4'd0, 4'(k));
      @(negedge clk);
      checks++;
      if (out_count !== 4'(k)) begin
        failures++;
        $display("FAIL wrap%0d got=%0d exp=%0d", k, out_count, 4'(k));
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_count !== 4'd1) begin failures++; $display("FAIL wrap_end got=%0d exp=1", out_count); end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_op_select();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitwise_result_stage.md
Name: bitwise_result_stage

Overview:
Registered downstream stage for the bitwise unit. It consumes the AND/OR/XOR vectors, selects one per transaction by opcode, and derives zero and parity flags. Results are buffered in a 2-entry queue behind a valid/ready handshake so the consumer can stall without losing data. It also keeps a running count of delivered results.

Parameters:
WIDTH, 4, operand/result width in bits; must match the feeding bitwise unit.
CNT_W, 16, width of delivered-transaction counter.

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream presents a transaction this cycle
in_ready  output  1  stage can accept a transaction this cycle
in_op  input  2  result select: 0 AND, 1 OR, 2 XOR, 3 XNOR
in_and  input  WIDTH  AND vector from bitwise unit
in_or  input  WIDTH  OR vector from bitwise unit
in_xor  input  WIDTH  XOR vector from bitwise unit
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out_result  output  WIDTH  selected result
out_zero  output  1  out_result == 0
out_parity  output  1  XOR-reduction of out_result (1 = odd ones)
out_count  output  CNT_W  number of completed output handshakes, wraps

Behaviour:
- Clock clk; reset rst is asynchronous and active-high: asserting rst immediately clears state regardless of clk.
- Reset values: in_ready=1 after reset releases (0 while rst high), out_valid=0, out_result=0, out_zero=1, out_parity=0, out_count=0, occupancy=0.
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Selection at push: op0 -> in_and, op1 -> in_or, op2 -> in_xor, op3 -> ~in_xor (WIDTH bits, no extension). Flags computed at push and stored with the entry.
- Storage: 2-entry FIFO (head/tail pointer, 2-bit occupancy 0..2). in_ready = (occupancy < 2), registered-state derived only; not combinationally dependent on out_ready.
- Latency: push in cycle N -> entry visible on out_* in cycle N+1 when queue was empty. No combinational in->out path.
- Outputs driven from head entry; stable while out_valid=1 and out_ready=0.
- Empty (occ=0): out_valid=0; out_result/out_zero/out_parity hold last popped values (reset values if none).
- Full (occ=2): in_ready=0; push ignored even if pop occurs same cycle; in_ready returns 1 the cycle after a pop.
- Simultaneous push and pop with occ=1: occupancy stays 1; new entry becomes head in next cycle.
- out_count increments by 1 on each pop; wraps 2^CNT_W-1 -> 0.
- rst asserted mid-operation: all queued entries discarded, counter cleared, in the same instant.
- in_op/in_* ignored when not pushing; X on unused inputs must not propagate.

Decomposition:
- Package bitwise_pkg: enum bw_op_e {BW_AND=0, BW_OR=1, BW_XOR=2, BW_XNOR=3} (2 bits); constant BW_WIDTH_DEFAULT=4; packed struct bw_entry_t {result, zero, parity} parameterised via WIDTH at module level.
- One sub-module: bitwise_fifo2 (generic 2-entry valid/ready FIFO, DATA_W parameter, clk/rst), holding bw_entry_t. Selection/flag logic stays in top.

Test Plan:
- Reset: hold rst high mid-stream with 2 entries queued -> out_valid=0, in_ready=0 during reset, out_count=0, in_ready=1 after release.
- Op select, a=4'b1100 b=4'b1010 (and=1000 or=1110 xor=0110), ops 0..3 with out_ready=1 -> results 1000,1110,0110,1001; parity 1,1,0,0; zero 0; each appears one cycle after push; out_count ends at 4.
- Zero flag: and=0000, op0 -> out_result=0000, out_zero=1, out_parity=0; XNOR with xor=1111 -> 0000, zero=1.
- Backpressure: out_ready=0, push 3 back-to-back -> first two accepted, in_ready=0 after second, third held by source; out_result stable; raise out_ready -> drained in order, no loss or duplication.
- Simultaneous push/pop at occ=1 over 10 cycles streaming -> one result per cycle, occupancy stays 1, out_count=10.
- Counter wrap with CNT_W=4: 17 pops -> out_count sequence reaches 15 then 0 then 1.
